midi_event_tx: RTL
==================

// Module: midi_event_tx
// PURPOSE
//  Converts which_note's (midi, note_on) stream into MIDI Note On/Note Off messages on a 31.25 kbaud 8N1 serial line.
//  Sits directly downstream of which_note and drives the MIDI OUT pin.
//  Level-based and self-coalescing: it always converges the sent state to the latest input state.
//  It never queues history.
// PARAMETERS
//  F_CLK     12_000_000  system clock frequency, Hz
//  BAUD      31_250      serial bit rate; BIT_CYCLES = F_CLK / BAUD, truncated (384 at defaults)
//  CHANNEL   0           MIDI channel 0..15, OR'd into the status low nibble
//  VELOCITY  100         Note On velocity, 1..127
// PORTS
//  clk      in   1  system clock, rising-edge
//  reset    in   1  asynchronous, active-high reset
//  midi     in   7  note number from which_note; don't-care (may be X) while note_on=0
//  note_on  in   1  1 = a note is currently detected
//  tx       out  1  MIDI serial output, idle high
//  busy     out  1  1 while a message is being transmitted
// BEHAVIOUR
//  Reset values
//   - tx=1, busy=0, sent_on=0, sent_note=0, FSM=IDLE.
//   - Reset asserted mid-message aborts immediately: tx returns high asynchronously.
//   - No Note Off is emitted for the aborted or previously sounding note.
//  Input capture
//   - midi and note_on are registered every clk (1 cycle).
//   - midi is compared only when the registered note_on=1, so X must never reach tx or the FSM.
//  Decision in IDLE, using registered inputs
//   - sent_on && (!note_on || midi != sent_note): send Note Off = {8'h80|CHANNEL, sent_note, 8'h40}; then sent_on <= 0.
//   - !sent_on && note_on: send Note On = {8'h90|CHANNEL, midi, VELOCITY}; then sent_on <= 1, sent_note <= midi.
//   - otherwise: stay in IDLE, busy=0.
//   - A note change therefore emits Off(old) followed by On(new), with exactly 1 IDLE clk (tx high) between them.
//   - No running status: every message carries its status byte.
//  Timing
//   - tx falls (start bit) 2 clk edges after an input change, when the block was IDLE.
//   - busy rises on the same edge that tx falls.
//   - busy falls on the edge that ends the last stop bit.
//   - Inputs are ignored while busy; the decision is re-evaluated in IDLE afterwards, so intermediate states are dropped.
//  FSM
//   - States: IDLE -> START -> DATA(bit 0..7) -> STOP -> {START of next byte | IDLE after byte 2}.
//   - Each state/bit lasts exactly BIT_CYCLES clocks.
//   - Data is sent LSB first; one stop bit; no gap between bytes of a message.
//   - sent_on and sent_note update on the edge that completes the last stop bit.
//  Widths
//   - Baud counter is $clog2(BIT_CYCLES) bits, wrapping at BIT_CYCLES-1.
//   - Bit index is 3 bits; byte index is 2 bits (0..2).
//   - Message duration is 30*BIT_CYCLES clocks (11_520 at defaults).
// STRUCTURE
//  sqmidi_pkg (shared)
//   - typedef logic [6:0] midi_note_t.
//   - Constants MIDI_NOTE_ON=4'h9, MIDI_NOTE_OFF=4'h8, NOTE_OFF_VELOCITY=7'h40, MIDI_BAUD=31_250.
//  Sub-module uart_tx #(F_CLK, BAUD)
//   - Ports: clk, reset, data[7:0], valid, ready, tx.
//   - Accepts a byte when valid && ready and transmits 8N1.
//   - Top level holds the event FSM and message sequencing.
// TESTING
//  1. Reset, then note_on=0, midi=X for 1 ms -> tx stays 1, busy stays 0, no X on either output.
//  2. note_on 0->1 with midi=69 -> bytes 0x90 0x45 0x64; start bit 2 clks after the change; each bit 384 clks.
//  3. From (2), note_on 1->0 -> bytes 0x80 0x45 0x40, then busy=0.
//  4. From (2), midi 69->76 with note_on held -> 0x80 0x45 0x40, 1 idle clk, then 0x90 0x4C 0x64.
//  5. With 69 sounding, midi pulses 69->70->69 while busy -> only the in-flight message completes, no further traffic.
//  6. Reset asserted mid-byte of a Note On -> tx=1 and busy=0 immediately.
//     After release with note_on=1, midi=76 -> a fresh 0x90 0x4C 0x64 is sent.

Source files
------------

// File: rtl/sqmidi_pkg.sv
// Shared MIDI types, constants and small byte-building helpers used by the
// event transmitter and its UART.
package sqmidi_pkg;

    typedef logic [6:0] midi_note_t;

    localparam logic [3:0] MIDI_NOTE_ON      = 4'h9;
    localparam logic [3:0] MIDI_NOTE_OFF     = 4'h8;
    localparam midi_note_t NOTE_OFF_VELOCITY = 7'h40;
    localparam int         MIDI_BAUD         = 31_250;

    // Serial framing states: one start bit, eight data bits, one stop bit.
    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    // Event sequencer: waiting for a state difference, or sending a message.
    typedef enum logic {
        EV_IDLE = 1'b0,
        EV_SEND = 1'b1
    } ev_state_e;

    // Status byte: message kind in the high nibble, channel in the low nibble.
    function automatic logic [7:0] midi_status(input logic [3:0] kind,
                                               input logic [3:0] chan);
        return {kind, chan};
    endfunction

    // Data bytes always have the top bit clear.
    function automatic logic [7:0] midi_data(input midi_note_t value);
        return {1'b0, value};
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 serial transmitter. A byte is taken when valid && ready; ready is also
// raised in the last cycle of a stop bit so consecutive bytes follow with no
// idle gap on the line.
module uart_tx
    import sqmidi_pkg::*;
#(
    parameter int F_CLK = 12_000_000,
    parameter int BAUD  = 31_250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int BIT_CYCLES = F_CLK / BAUD;
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    uart_state_e      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             tx_r;
    logic             bit_end_s;
    logic             ready_s;

    assign bit_end_s = (cnt_r == CNT_LAST);

    // Ready when idle, or in the final cycle of a stop bit for back-to-back bytes.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            UART_IDLE: ready_s = 1'b1;
            UART_STOP: ready_s = bit_end_s;
            default:   ready_s = 1'b0;
        endcase
    end

    // Framing state machine with a registered line output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= UART_IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
        end else begin
            case (state_r)
                UART_IDLE: begin
                    cnt_r     <= '0;
                    bit_idx_r <= 3'd0;
                    if (valid) begin
                        shift_r <= data;
                        tx_r    <= 1'b0;
                        state_r <= UART_START;
                    end else begin
                        tx_r    <= 1'b1;
                    end
                end
                UART_START: begin
                    if (bit_end_s) begin
                        cnt_r     <= '0;
                        bit_idx_r <= 3'd0;
                        tx_r      <= shift_r[0];
                        state_r   <= UART_DATA;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                UART_DATA: begin
                    if (bit_end_s) begin
                        cnt_r <= '0;
                        if (bit_idx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= UART_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                UART_STOP: begin
                    if (bit_end_s) begin
                        cnt_r <= '0;
                        if (valid) begin
                            shift_r <= data;
                            tx_r    <= 1'b0;
                            state_r <= UART_START;
                        end else begin
                            tx_r    <= 1'b1;
                            state_r <= UART_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    tx_r    <= 1'b1;
                    state_r <= UART_IDLE;
                end
            endcase
        end
    end

    assign ready = ready_s;
    assign tx    = tx_r;

endmodule

// File: rtl/midi_event_tx.sv
// Turns the (midi, note_on) level stream into MIDI Note On / Note Off
// messages. It remembers only what the far end was last told (sent_on,
// sent_note) and, whenever idle, sends one message that moves that state
// toward the current input; inputs seen while busy are simply superseded.
module midi_event_tx
    import sqmidi_pkg::*;
#(
    parameter int F_CLK    = 12_000_000,
    parameter int BAUD     = MIDI_BAUD,
    parameter int CHANNEL  = 0,
    parameter int VELOCITY = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] midi,
    input  logic       note_on,
    output logic       tx,
    output logic       busy
);

    localparam logic [3:0] CHAN = 4'(CHANNEL);
    localparam midi_note_t VEL  = 7'(VELOCITY);

    midi_note_t midi_r;
    logic       note_on_r;
    midi_note_t sent_note_r;
    logic       sent_on_r;
    ev_state_e  state_r;
    logic [1:0] byte_idx_r;
    logic [7:0] msg_b1_r;
    logic [7:0] msg_b2_r;
    logic       pend_on_r;
    midi_note_t pend_note_r;
    logic       busy_r;

    logic       need_off_s;
    logic       need_on_s;
    logic       uart_valid_s;
    logic [7:0] uart_data_s;
    logic       uart_ready_s;

    // Register inputs; the note number is forced to zero while no note is
    // detected so an undefined note never propagates into the decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note_on_r <= 1'b0;
            midi_r    <= 7'd0;
        end else begin
            note_on_r <= note_on;
            midi_r    <= note_on ? midi : 7'd0;
        end
    end

    // Decide which message, if any, brings the sent state to the input state.
    always_comb begin
        need_off_s = 1'b0;
        need_on_s  = 1'b0;
        if (sent_on_r) begin
            if (!note_on_r) begin
                need_off_s = 1'b1;
            end else if (midi_r != sent_note_r) begin
                need_off_s = 1'b1;
            end else begin
                need_off_s = 1'b0;
            end
        end else begin
            need_on_s = note_on_r;
        end
    end

    // Byte offered to the UART: the status byte when starting a message,
    // then the two data bytes latched at the start of the message.
    always_comb begin
        uart_valid_s = 1'b0;
        uart_data_s  = 8'h00;
        case (state_r)
            EV_IDLE: begin
                if (need_off_s) begin
                    uart_valid_s = 1'b1;
                    uart_data_s  = midi_status(MIDI_NOTE_OFF, CHAN);
                end else if (need_on_s) begin
                    uart_valid_s = 1'b1;
                    uart_data_s  = midi_status(MIDI_NOTE_ON, CHAN);
                end else begin
                    uart_valid_s = 1'b0;
                    uart_data_s  = 8'h00;
                end
            end
            EV_SEND: begin
                if (byte_idx_r != 2'd2) begin
                    uart_valid_s = 1'b1;
                    uart_data_s  = (byte_idx_r == 2'd0) ? msg_b1_r : msg_b2_r;
                end else begin
                    uart_valid_s = 1'b0;
                    uart_data_s  = 8'h00;
                end
            end
            default: begin
                uart_valid_s = 1'b0;
                uart_data_s  = 8'h00;
            end
        endcase
    end

    // Message sequencer; byte_idx_r is the byte currently on the line and
    // the sent state is committed when the final stop bit completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= EV_IDLE;
            byte_idx_r  <= 2'd0;
            msg_b1_r    <= 8'h00;
            msg_b2_r    <= 8'h00;
            pend_on_r   <= 1'b0;
            pend_note_r <= 7'd0;
            sent_on_r   <= 1'b0;
            sent_note_r <= 7'd0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                EV_IDLE: begin
                    byte_idx_r <= 2'd0;
                    if (uart_valid_s && uart_ready_s) begin
                        state_r <= EV_SEND;
                        busy_r  <= 1'b1;
                        if (need_off_s) begin
                            msg_b1_r    <= midi_data(sent_note_r);
                            msg_b2_r    <= midi_data(NOTE_OFF_VELOCITY);
                            pend_on_r   <= 1'b0;
                            pend_note_r <= sent_note_r;
                        end else begin
                            msg_b1_r    <= midi_data(midi_r);
                            msg_b2_r    <= midi_data(VEL);
                            pend_on_r   <= 1'b1;
                            pend_note_r <= midi_r;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                EV_SEND: begin
                    if (uart_ready_s) begin
                        if (byte_idx_r == 2'd2) begin
                            state_r     <= EV_IDLE;
                            busy_r      <= 1'b0;
                            byte_idx_r  <= 2'd0;
                            sent_on_r   <= pend_on_r;
                            sent_note_r <= pend_note_r;
                        end else begin
                            byte_idx_r <= byte_idx_r + 2'd1;
                        end
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= EV_IDLE;
                    busy_r     <= 1'b0;
                    byte_idx_r <= 2'd0;
                end
            endcase
        end
    end

    uart_tx #(
        .F_CLK (F_CLK),
        .BAUD  (BAUD)
    ) u_uart_tx (
        .clk   (clk),
        .reset (reset),
        .data  (uart_data_s),
        .valid (uart_valid_s),
        .ready (uart_ready_s),
        .tx    (tx)
    );

    assign busy = busy_r;

endmodule
